rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
- Parametrised successor to the 8x32 single-read register file.
- Provides one write port and two independent read ports (A, B), each with a read-enable.
- Reads are registered: one-cycle latency with a valid strobe, and write-to-read bypass on address collision.
- Sits between the datapath controller and the matrix compute units; lets two operands be fetched per cycle.

Parameters:
- DATA_W, 32, word width in bits (>=1).
- DEPTH, 8, number of entries (power of two, >=2).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- ZERO_REG, 0, if 1, entry 0 is hardwired to zero: writes ignored, reads return 0.

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- clear  in  1  Asynchronous, active-low reset.
- we  in  1  Write enable.
- wAddr  in  ADDR_W  Write address.
- wData  in  DATA_W  Write data.
- reA  in  1  Read enable, port A.
- rAddrA  in  ADDR_W  Read address, port A.
- reB  in  1  Read enable, port B.
- rAddrB  in  ADDR_W  Read address, port B.
- rDataA  out  DATA_W  Registered read data, port A.
- rValidA  out  1  rDataA valid; high for one cycle following a cycle with reA=1.
- rDataB  out  DATA_W  Registered read data, port B.
- rValidB  out  1  rDataB valid.
- perrA  out  1  Parity error on port A read; present only with RF_PARITY_EN, otherwise tied 0.
- perrB  out  1  Parity error on port B read; same rule as perrA.

Behaviour:
- Reset (clear=0, asynchronous): every entry = 0; rDataA/B = 0; rValidA/B = 0; perrA/B = 0. Reset asserted mid-operation discards any in-flight read; rValid drops immediately.
- Write: on a rising edge with we=1, entry[wAddr] <= wData. The new value is visible in storage from the next cycle.
- Read, per port X, independently:
  - On a rising edge with reX=1, rDataX <= entry[rAddrX] and rValidX <= 1. Latency is 1 cycle.
  - With reX=0: rValidX <= 0 and rDataX holds its previous value.
- Bypass: if we=1, reX=1 and rAddrX==wAddr in the same cycle, rDataX <= wData (new data, not stale). Applies to both ports simultaneously.
- Both ports may read the same address in the same cycle; both return identical data.
- ZERO_REG=1:
  - A write to address 0 has no effect.
  - A read of address 0 returns 0, including the bypass case (bypass suppressed for address 0).
- Addresses are always in range: DEPTH is a power of two, so there is no out-of-range case.
- No back-pressure: a read may issue every cycle on each port; back-to-back reads give continuous rValid.
- Write and read enables are fully independent; no arbitration and no stall.

Optional Feature:
- Macro: RF_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit, computed from wData at write time; reset value of every parity bit is 0.
  - On read, the parity of the stored data is recomputed; perrX <= (recomputed != stored), registered alongside rDataX and valid only when rValidX=1.
  - A bypassed read recomputes parity from wData, so perrX=0.
  - Parity storage is observable by the bench through a hierarchical force, used to inject errors.
- Not defined: no parity storage; perrA/B are constant 0.

Test Plan:
- Reset mid-stream: write 0xDEADBEEF to addr 3, issue reA on addr 3, drop clear before the next edge -> rValidA=0 and rDataA=0 immediately; a subsequent read of addr 3 returns 0x00000000.
- Write then dual read: write 0x11111111 to addr 5 and 0x22222222 to addr 6; next cycle reA@5, reB@6 -> one cycle later rDataA=0x11111111, rDataB=0x22222222, both rValid=1.
- Same-cycle bypass: addr 2 holds 0xAAAA0000; we=1, wAddr=2, wData=0x12345678, reA=reB=1 at addr 2 -> next cycle both ports = 0x12345678; a read the cycle after also returns 0x12345678.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0 with reA@0 in the same cycle -> rDataA=0; a later read of addr 0 also returns 0.
- Parameter sweep: DATA_W=16, DEPTH=32; write addr k with data k*3 for k=0..31, then read all entries on both ports back-to-back -> every word matches and rValid stays high continuously.
- RF_PARITY_EN: write 0x0000000F to addr 1, force-flip its stored parity bit, reB@1 -> rDataB=0x0000000F, perrB=1; reading an unflipped entry gives perrB=0.

Source files
------------

// File: rtl/rf_multiport.sv
// Multi-port register file: one write port, two registered read ports with write bypass.
// Optional per-entry even parity with read-side error flags when RF_PARITY_EN is defined.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic              reA,
    input  logic [ADDR_W-1:0] rAddrA,
    input  logic              reB,
    input  logic [ADDR_W-1:0] rAddrB,
    output logic [DATA_W-1:0] rDataA,
    output logic              rValidA,
    output logic [DATA_W-1:0] rDataB,
    output logic              rValidB,
    output logic              perrA,
    output logic              perrB
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              rvalid_a_q, rvalid_b_q;
    logic              wr_en;
    logic              zero_a, zero_b;
    logic              byp_a, byp_b;

    // Entry 0 is pinned to zero when ZERO_REG is set, so it neither stores nor bypasses.
    assign wr_en  = we && !((ZERO_REG != 0) && (wAddr == '0));
    assign zero_a = (ZERO_REG != 0) && (rAddrA == '0);
    assign zero_b = (ZERO_REG != 0) && (rAddrB == '0);
    assign byp_a  = we && (rAddrA == wAddr) && !zero_a;
    assign byp_b  = we && (rAddrB == wAddr) && !zero_b;

    always_comb begin
        rdata_a_d = rdata_a_q;
        if (reA) begin
            if (zero_a) begin
                rdata_a_d = '0;
            end else if (byp_a) begin
                rdata_a_d = wData;
            end else begin
                rdata_a_d = mem_q[rAddrA];
            end
        end
    end

    always_comb begin
        rdata_b_d = rdata_b_q;
        if (reB) begin
            if (zero_b) begin
                rdata_b_d = '0;
            end else if (byp_b) begin
                rdata_b_d = wData;
            end else begin
                rdata_b_d = mem_q[rAddrB];
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wAddr] <= wData;
            end
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_a_q <= reA;
            rvalid_b_q <= reB;
        end
    end

    assign rDataA  = rdata_a_q;
    assign rDataB  = rdata_b_q;
    assign rValidA = rvalid_a_q;
    assign rValidB = rvalid_b_q;

`ifdef RF_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             perr_a_q, perr_a_d;
    logic             perr_b_q, perr_b_d;

    // A bypassed word never touched storage, so its parity is good by construction.
    always_comb begin
        perr_a_d = perr_a_q;
        if (reA) begin
            perr_a_d = (zero_a || byp_a) ? 1'b0 : ((^mem_q[rAddrA]) != par_q[rAddrA]);
        end
    end

    always_comb begin
        perr_b_d = perr_b_q;
        if (reB) begin
            perr_b_d = (zero_b || byp_b) ? 1'b0 : ((^mem_q[rAddrB]) != par_q[rAddrB]);
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            par_q    <= '0;
            perr_a_q <= 1'b0;
            perr_b_q <= 1'b0;
        end else begin
            if (wr_en) begin
                par_q[wAddr] <= ^wData;
            end
            perr_a_q <= perr_a_d;
            perr_b_q <= perr_b_d;
        end
    end

    assign perrA = perr_a_q;
    assign perrB = perr_b_q;
`else
    assign perrA = 1'b0;
    assign perrB = 1'b0;
`endif

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: directed vector table, reset/bypass/zero-register sequences,
// random traffic against an array model, a 16x32 sweep and (with RF_PARITY_EN) parity injection.
module tb_rf_multiport;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    // Instance 1: default 32-bit x 8, ZERO_REG=0
    logic        we1, reA1, reB1;
    logic [2:0]  wa1, raA1, raB1;
    logic [31:0] wd1, rdA1, rdB1;
    logic        rvA1, rvB1, peA1, peB1;

    // Instance 2: 16-bit x 32, ZERO_REG=1
    logic        we2, reA2, reB2;
    logic [4:0]  wa2, raA2, raB2;
    logic [15:0] wd2, rdA2, rdB2;
    logic        rvA2, rvB2, peA2, peB2;

    rf_multiport dut1 (
        .clk(clk), .clear(clear), .we(we1), .wAddr(wa1), .wData(wd1),
        .reA(reA1), .rAddrA(raA1), .reB(reB1), .rAddrB(raB1),
        .rDataA(rdA1), .rValidA(rvA1), .rDataB(rdB1), .rValidB(rvB1),
        .perrA(peA1), .perrB(peB1)
    );

    rf_multiport #(.DATA_W(16), .DEPTH(32), .ZERO_REG(1)) dut2 (
        .clk(clk), .clear(clear), .we(we2), .wAddr(wa2), .wData(wd2),
        .reA(reA2), .rAddrA(raA2), .reB(reB2), .rAddrB(raB2),
        .rDataA(rdA2), .rValidA(rvA2), .rDataB(rdB2), .rValidB(rvB2),
        .perrA(peA2), .perrB(peB2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        we1 = 0; wa1 = 0; wd1 = 0; reA1 = 0; raA1 = 0; reB1 = 0; raB1 = 0;
        we2 = 0; wa2 = 0; wd2 = 0; reA2 = 0; raA2 = 0; reB2 = 0; raB2 = 0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        rea;
        logic [2:0]  raa;
        logic        reb;
        logic [2:0]  rab;
        logic        eva;
        logic [31:0] eda;
        logic        evb;
        logic [31:0] edb;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] m1 [8];
    logic [15:0] m2 [32];
    logic [31:0] e_da1, e_db1;
    logic [15:0] e_da2, e_db2;

    initial begin
        // Watchdog: the bench has only bounded loops, this catches a stuck clock.
        #2_000_000;
        $display("FAIL watchdog: time %0t, limit reached", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 3'd5, 32'h11111111, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b1, 3'd6, 32'h22222222, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 32'h11111111, 1'b1, 32'h22222222};
        vecs[3] = '{1'b1, 3'd2, 32'hAAAA0000, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 32'h11111111, 1'b0, 32'h22222222};
        vecs[4] = '{1'b1, 3'd2, 32'h12345678, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 32'h12345678, 1'b1, 32'h12345678};
        vecs[5] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 32'h12345678, 1'b1, 32'h12345678};
        vecs[6] = '{1'b1, 3'd7, 32'hCAFEF00D, 1'b1, 3'd7, 1'b1, 3'd5, 1'b1, 32'hCAFEF00D, 1'b1, 32'h11111111};
        vecs[7] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd6, 1'b0, 3'd0, 1'b1, 32'h22222222, 1'b0, 32'h11111111};

        idle_all();
        clear = 1'b0;
        repeat (2) tick();
        chk("rst.rvA1", {31'b0, rvA1}, 0);
        chk("rst.rdA1", rdA1, 0);
        chk("rst.rvB1", {31'b0, rvB1}, 0);
        chk("rst.rdB1", rdB1, 0);
        chk("rst.peA1", {31'b0, peA1}, 0);
        chk("rst.rdA2", {16'b0, rdA2}, 0);
        chk("rst.rvB2", {31'b0, rvB2}, 0);
        clear = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            we1 = vecs[i].we; wa1 = vecs[i].wa; wd1 = vecs[i].wd;
            reA1 = vecs[i].rea; raA1 = vecs[i].raa; reB1 = vecs[i].reb; raB1 = vecs[i].rab;
            tick();
            chk($sformatf("vec%0d.rvA", i), {31'b0, rvA1}, {31'b0, vecs[i].eva});
            chk($sformatf("vec%0d.rdA", i), rdA1, vecs[i].eda);
            chk($sformatf("vec%0d.rvB", i), {31'b0, rvB1}, {31'b0, vecs[i].evb});
            chk($sformatf("vec%0d.rdB", i), rdB1, vecs[i].edb);
        end

        // Reset in the middle of traffic
        idle_all();
        we1 = 1; wa1 = 3; wd1 = 32'hDEADBEEF; reA1 = 1; raA1 = 3;
        tick();
        chk("midrst.pre.rvA", {31'b0, rvA1}, 1);
        chk("midrst.pre.rdA", rdA1, 32'hDEADBEEF);
        idle_all();
        #3 clear = 1'b0;
        #1;
        chk("midrst.rvA", {31'b0, rvA1}, 0);
        chk("midrst.rdA", rdA1, 0);
        tick();
        clear = 1'b1;
        reA1 = 1; raA1 = 3;
        tick();
        chk("midrst.after.rvA", {31'b0, rvA1}, 1);
        chk("midrst.after.rdA", rdA1, 0);
        idle_all();
        tick();

        // Zero register on instance 2
        we2 = 1; wa2 = 0; wd2 = 16'hFFFF; reA2 = 1; raA2 = 0;
        tick();
        chk("zero.byp.rvA", {31'b0, rvA2}, 1);
        chk("zero.byp.rdA", {16'b0, rdA2}, 0);
        idle_all();
        reA2 = 1; raA2 = 0; reB2 = 1; raB2 = 0;
        tick();
        chk("zero.later.rdA", {16'b0, rdA2}, 0);
        chk("zero.later.rdB", {16'b0, rdB2}, 0);
        idle_all();
        tick();

        // Random traffic against array models (both instances start from all-zero storage)
        for (int i = 0; i < 8; i++) m1[i] = 0;
        for (int i = 0; i < 32; i++) m2[i] = 0;
        e_da1 = rdA1 === 32'h0 ? 32'h0 : 32'hX; e_db1 = 32'h0;
        e_da1 = 32'h0;
        e_da2 = 16'h0; e_db2 = 16'h0;
        for (int n = 0; n < 250; n++) begin
            we1 = 1'($urandom_range(0, 1)); wa1 = 3'($urandom); wd1 = $urandom;
            reA1 = 1'($urandom_range(0, 1)); raA1 = 3'($urandom);
            reB1 = 1'($urandom_range(0, 1)); raB1 = 3'($urandom);
            we2 = 1'($urandom_range(0, 1)); wd2 = 16'($urandom);
            wa2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            reA2 = 1'($urandom_range(0, 1));
            raA2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            reB2 = 1'($urandom_range(0, 1));
            raB2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);

            if (reA1) e_da1 = (we1 && raA1 == wa1) ? wd1 : m1[raA1];
            if (reB1) e_db1 = (we1 && raB1 == wa1) ? wd1 : m1[raB1];
            if (reA2) e_da2 = (raA2 == 0) ? 16'h0 : (we2 && raA2 == wa2) ? wd2 : m2[raA2];
            if (reB2) e_db2 = (raB2 == 0) ? 16'h0 : (we2 && raB2 == wa2) ? wd2 : m2[raB2];

            tick();
            chk($sformatf("rnd%0d.rvA1", n), {31'b0, rvA1}, {31'b0, reA1});
            chk($sformatf("rnd%0d.rdA1", n), rdA1, e_da1);
            chk($sformatf("rnd%0d.rvB1", n), {31'b0, rvB1}, {31'b0, reB1});
            chk($sformatf("rnd%0d.rdB1", n), rdB1, e_db1);
            chk($sformatf("rnd%0d.pe1", n), {30'b0, peA1, peB1}, 0);
            chk($sformatf("rnd%0d.rvA2", n), {31'b0, rvA2}, {31'b0, reA2});
            chk($sformatf("rnd%0d.rdA2", n), {16'b0, rdA2}, {16'b0, e_da2});
            chk($sformatf("rnd%0d.rvB2", n), {31'b0, rvB2}, {31'b0, reB2});
            chk($sformatf("rnd%0d.rdB2", n), {16'b0, rdB2}, {16'b0, e_db2});
            chk($sformatf("rnd%0d.pe2", n), {30'b0, peA2, peB2}, 0);

            if (we1) m1[wa1] = wd1;
            if (we2 && wa2 != 0) m2[wa2] = wd2;
        end
        idle_all();
        tick();

        // Sweep on the 16x32 instance: fill with k*3, then stream reads on both ports
        for (int k = 0; k < 32; k++) begin
            we2 = 1; wa2 = 5'(k); wd2 = 16'(k * 3);
            tick();
        end
        idle_all();
        for (int k = 0; k < 32; k++) begin
            reA2 = 1; raA2 = 5'(k); reB2 = 1; raB2 = 5'(31 - k);
            tick();
            chk($sformatf("sweep%0d.rvA", k), {31'b0, rvA2}, 1);
            chk($sformatf("sweep%0d.rdA", k), {16'b0, rdA2}, 32'(k * 3));
            chk($sformatf("sweep%0d.rvB", k), {31'b0, rvB2}, 1);
            chk($sformatf("sweep%0d.rdB", k), {16'b0, rdB2}, 32'((31 - k) * 3));
        end
        idle_all();
        tick();
        chk("sweep.end.rvA", {31'b0, rvA2}, 0);

`ifdef RF_PARITY_EN
        begin
            logic [7:0] pv;
            we1 = 1; wa1 = 1; wd1 = 32'h0000000F;
            tick();
            wa1 = 4; wd1 = 32'h00000007;
            tick();
            idle_all();
            pv = dut1.par_q;
            force dut1.par_q = pv ^ 8'h02;
            reB1 = 1; raB1 = 1;
            tick();
            chk("par.flip.rdB", rdB1, 32'h0000000F);
            chk("par.flip.perrB", {31'b0, peB1}, 1);
            raB1 = 4;
            tick();
            chk("par.clean.rdB", rdB1, 32'h00000007);
            chk("par.clean.perrB", {31'b0, peB1}, 0);
            release dut1.par_q;
            idle_all();
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
